bist_scheduler: RTL

BIST_SCHEDULER -- requirements
Module: bist_scheduler

---
 rtl/bist_scheduler_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/bist_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bist_scheduler_pkg.sv
// Shared definitions for the BIST scheduler: FSM encoding, default sizing and timer width.
package bist_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARB     = 3'd1,
      S_ARM     = 3'd2,
      S_RUN     = 3'd3,
      S_CHECK   = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   localparam int NREQ_DEF  = 4;
   localparam int SIG_W_DEF = 16;
   localparam int TMO_DEF   = 255;
   localparam int CNT_W     = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index.
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic              update,
   output logic [NREQ-1:0]   gnt,
   output logic [IDX_W-1:0]  idx
);

   logic [IDX_W-1:0] last;
   logic [IDX_W-1:0] cand;

   // Scan from farthest to nearest so the nearest requester after 'last' wins.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      cand = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDX_W'((int'(last) + k) % NREQ);
         if (req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

   // Reset to the top index so index 0 is served first.
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= IDX_W'(NREQ - 1);
      end else if (update) begin
         last <= idx;
      end
   end

endmodule

// File: rtl/bist_scheduler.sv
// Shares one BIST controller among NREQ CUTs: round-robin grant, start handshake,
// signature check and run timeout.
//
// state   | meaning
// IDLE    | no request pending, START low
// ARB     | pick next requester, switch mux
// ARM     | START high, wait for BIST_END low
// RUN     | START high, wait for BIST_END high or timeout
// CHECK   | signature result and DONE visible, START held
// RELEASE | START low for two cycles before the next run
module bist_scheduler
   import bist_scheduler_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int SIG_W = SIG_W_DEF,
   parameter int TMO   = TMO_DEF
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [NREQ-1:0]          REQ,
   input  logic                     BIST_END,
   input  logic [SIG_W-1:0]         SIG,
   input  logic [SIG_W-1:0]         GOLDEN,
   output logic                     START,
   output logic [$clog2(NREQ)-1:0]  CUT_SEL,
   output logic [NREQ-1:0]          GNT,
   output logic [NREQ-1:0]          DONE,
   output logic [NREQ-1:0]          PASS,
   output logic                     BUSY,
   output logic                     TIMEOUT
);

   localparam int IDX_W = $clog2(NREQ);
   localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             rel_cnt;
   logic [NREQ-1:0]  arb_gnt;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_update;

   assign arb_update = (state == S_ARB) && (|arb_gnt);

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk    (CLK),
      .reset  (RESET),
      .req    (REQ),
      .update (arb_update),
      .gnt    (arb_gnt),
      .idx    (arb_idx)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= S_IDLE;
         cnt     <= '0;
         rel_cnt <= 1'b0;
         START   <= 1'b0;
         CUT_SEL <= '0;
         GNT     <= '0;
         DONE    <= '0;
         PASS    <= '0;
         BUSY    <= 1'b0;
         TIMEOUT <= 1'b0;
      end else begin
         DONE <= '0;
         case (state)
            S_IDLE: begin
               if (|REQ) begin
                  state <= S_ARB;
                  BUSY  <= 1'b1;
               end
            end
            S_ARB: begin
               if (|arb_gnt) begin
                  state   <= S_ARM;
                  GNT     <= arb_gnt;
                  CUT_SEL <= arb_idx;
                  START   <= 1'b1;
                  cnt     <= '0;
               end else begin
                  state <= S_IDLE;
                  GNT   <= '0;
                  BUSY  <= 1'b0;
               end
            end
            // A completion seen in the terminal-count cycle wins over the timeout.
            S_ARM, S_RUN: begin
               if (state == S_RUN && BIST_END) begin
                  state         <= S_CHECK;
                  PASS[CUT_SEL] <= (SIG == GOLDEN);
                  DONE[CUT_SEL] <= 1'b1;
               end else if (cnt == TMO_C) begin
                  state         <= S_RELEASE;
                  rel_cnt       <= 1'b0;
                  START         <= 1'b0;
                  TIMEOUT       <= 1'b1;
                  PASS[CUT_SEL] <= 1'b0;
                  DONE[CUT_SEL] <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (state == S_ARM && !BIST_END) begin
                     state <= S_RUN;
                  end
               end
            end
            S_CHECK: begin
               state   <= S_RELEASE;
               rel_cnt <= 1'b0;
               START   <= 1'b0;
            end
            S_RELEASE: begin
               if (!rel_cnt) begin
                  rel_cnt <= 1'b1;
               end else if (|REQ) begin
                  state <= S_ARB;
               end else begin
                  state <= S_IDLE;
                  GNT   <= '0;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               START <= 1'b0;
               GNT   <= '0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule
